cpu_pipeline_control: RTL and testbench
=======================================

# cpu_pipeline_control

Hazard and flush sequencer for the CPU's five-stage pipeline. Every cycle it decides whether fetch, decode and execute advance, hold, take a bubble or are killed. It covers the hazards operand forwarding cannot resolve: load-use, a multi-cycle execute unit, a stalled memory bus, and control-flow redirects. It also keeps two 32-bit performance counters (stall cycles, flush events).

## Interface
Parameters:
- FLUSH_CYCLES, 2, number of consecutive cycles `o_flush` stays asserted per redirect; legal range 1..7.

Ports:
- i_clock  in  1  system clock; every register updates on its rising edge.
- i_reset  in  1  synchronous, active-high reset.
- i_decode_valid  in  1  decode holds a valid instruction.
- i_decode_have_rs  in  2  bit0: instruction reads rs1; bit1: instruction reads rs2.
- i_decode_rs1, i_decode_rs2  in  5  source register indices.
- i_execute_valid  in  1  execute holds a valid instruction.
- i_execute_load  in  1  the instruction in execute is a load.
- i_execute_rd  in  5  destination register index of the execute instruction.
- i_execute_busy  in  1  multi-cycle execute operation has not finished.
- i_memory_busy  in  1  memory stage has a bus transaction outstanding.
- i_redirect  in  1  execute resolved a taken branch, jump or trap this cycle (pulse).
- o_fetch_stall, o_decode_stall, o_execute_stall  out  1  hold the stage register.
- o_execute_bubble  out  1  load a NOP into execute instead of the decode output.
- o_flush  out  1  kill the fetch and decode contents.
- o_stall_cycles  out  32  count of cycles with `o_decode_stall` = 1.
- o_flush_events  out  32  count of redirects accepted.

## Operation
- State register with three states: RUN, FLUSH, PENDING. It holds a 3-bit flush counter `fc`.
- Load-use hazard `luh` is true when all of the following hold: `i_decode_valid`, `i_execute_valid`, `i_execute_load`, `i_execute_rd` != 0, and either (`have_rs[0]` and rs1 == rd) or (`have_rs[1]` and rs2 == rd).
- Outputs are combinational from state, `fc` and inputs. Priority within a cycle, highest first:
  - **memory busy.** When `i_memory_busy` = 1, all three stalls are 1.
    - In RUN: if `i_redirect` = 1, go to PENDING. No flush this cycle.
    - In FLUSH: `o_flush` stays 1 and `fc` is frozen.
  - **redirect accepted.** Applies when `i_redirect` = 1 in RUN or FLUSH, or when in PENDING, and `i_memory_busy` = 0.
    - Outputs: `o_flush` = 1, `o_execute_bubble` = 1.
    - Counters: `o_flush_events` += 1.
    - If FLUSH_CYCLES > 1: go to FLUSH and load `fc` = FLUSH_CYCLES-1.
    - Otherwise: go to RUN.
    - A redirect arriving in FLUSH restarts the count.
  - **FLUSH, no redirect.** `o_flush` = 1 and `o_execute_bubble` = 1.
    - `fc` decrements each cycle; go to RUN on the cycle `fc` = 1.
    - `luh` is ignored in this state.
  - **RUN, `i_execute_busy` = 1.**
    - `o_fetch_stall` = 1, `o_decode_stall` = 1.
    - `o_execute_stall` = 0, because the execute stage holds itself.
  - **RUN, `luh` = 1.**
    - `o_fetch_stall` = 1, `o_decode_stall` = 1, `o_execute_bubble` = 1.
    - One bubble per load; the hazard clears the next cycle as the load advances to memory.
  - **Otherwise.** All outputs 0.
- In FLUSH, `i_execute_busy` also asserts `o_fetch_stall` and `o_decode_stall` alongside `o_flush`. The `fc` countdown continues.
- `o_stall_cycles` increments in every cycle where `o_decode_stall` = 1.
- Both counters wrap modulo 2^32.

## Timing
- Reset: while `i_reset` = 1, every output is 0, state is RUN, `fc` = 0 and both counters are 0. The first non-reset cycle behaves as RUN.
- Reset mid-operation aborts FLUSH or PENDING immediately; a pending redirect is discarded.
- Zero latency: stall, bubble and flush respond in the same cycle as the causing input.
- One redirect raises `o_flush` for exactly FLUSH_CYCLES consecutive non-memory-busy cycles, starting in the cycle it is accepted.
- A redirect held in PENDING is accepted in the first cycle `i_memory_busy` = 0. It is counted once.
- A second `i_redirect` while in PENDING merges with the pending one and is not counted again.
- `i_execute_rd` = 0 never causes a load-use stall.

## Test plan
- **Load-use.** Load writing x5 in execute; decode reads rs2 = x5 with `have_rs` = 2'b10. Expect exactly one cycle of fetch/decode stall plus bubble, then `o_stall_cycles` = 1.
- **x0 / unread operand.** Load writing x0 with decode rs1 = x0: no stall. Load writing x7 with decode rs1 = x7 but `have_rs` = 0: no stall.
- **Redirect, default parameter.** `i_redirect` pulse in RUN with FLUSH_CYCLES = 2. Expect `o_flush` = 1 in cycles T and T+1, 0 at T+2, and `o_flush_events` = 1. Repeat with FLUSH_CYCLES = 1: flush only in cycle T.
- **Redirect under memory busy.** `i_redirect` with `i_memory_busy` = 1 for 3 cycles. Expect all stalls = 1 and no flush for those 3 cycles; flush starts in cycle 4; `o_flush_events` = 1.
- **Back-to-back redirects.** Second `i_redirect` one cycle into FLUSH with FLUSH_CYCLES = 3. Expect flush held for 4 cycles total and `o_flush_events` = 2.
- **Execute busy.** `i_execute_busy` held 5 cycles in RUN. Expect fetch/decode stall, `o_execute_stall` = 0, `o_stall_cycles` = 5. Assert `i_reset` on cycle 3 of a FLUSH: the next cycle has all outputs 0 and both counters 0.

Source files
------------

// File: rtl/cpu_pipeline_control.sv
// cpu_pipeline_control
//   Hazard and flush sequencer for the five-stage pipeline. Each cycle it
//   decides whether fetch, decode and execute advance, hold, take a bubble
//   or are killed. It also keeps two 32-bit performance counters.
// Ports
//   i_clock, i_reset            clock, synchronous active-high reset
//   i_decode_*                  decode-stage instruction and its source operands
//   i_execute_*                 execute-stage instruction, load flag, rd, busy
//   i_memory_busy               memory stage has a bus transaction outstanding
//   i_redirect                  taken branch / jump / trap resolved in execute
//   o_*_stall, o_execute_bubble, o_flush   pipeline control (combinational)
//   o_stall_cycles, o_flush_events         performance counters
module cpu_pipeline_control #(
  parameter int FLUSH_CYCLES = 2
) (
  input  logic        i_clock,
  input  logic        i_reset,
  input  logic        i_decode_valid,
  input  logic [1:0]  i_decode_have_rs,
  input  logic [4:0]  i_decode_rs1,
  input  logic [4:0]  i_decode_rs2,
  input  logic        i_execute_valid,
  input  logic        i_execute_load,
  input  logic [4:0]  i_execute_rd,
  input  logic        i_execute_busy,
  input  logic        i_memory_busy,
  input  logic        i_redirect,
  output logic        o_fetch_stall,
  output logic        o_decode_stall,
  output logic        o_execute_stall,
  output logic        o_execute_bubble,
  output logic        o_flush,
  output logic [31:0] o_stall_cycles,
  output logic [31:0] o_flush_events
);

  localparam logic [1:0] RUN     = 2'd0;
  localparam logic [1:0] FLUSH   = 2'd1;
  localparam logic [1:0] PENDING = 2'd2;

  // fc is loaded with the number of flush cycles still owed after the
  // accepting cycle itself.
  localparam logic [2:0] FC_LOAD = 3'(FLUSH_CYCLES - 1);
  localparam bit         MULTI   = (FLUSH_CYCLES > 1);

  logic [1:0]  state_q, state_d;
  logic [2:0]  fc_q, fc_d;
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] flush_cnt_q, flush_cnt_d;

  logic luh;
  logic fetch_stall, decode_stall, execute_stall, execute_bubble, flush;
  logic accept;

  // Load-use hazard: the loaded value is not forwardable until the load
  // reaches memory, so decode must wait one cycle. x0 is never a real dest.
  assign luh = i_decode_valid && i_execute_valid && i_execute_load &&
               (i_execute_rd != 5'd0) &&
               ((i_decode_have_rs[0] && (i_decode_rs1 == i_execute_rd)) ||
                (i_decode_have_rs[1] && (i_decode_rs2 == i_execute_rd)));

  always_comb begin
    state_d        = state_q;
    fc_d           = fc_q;
    fetch_stall    = 1'b0;
    decode_stall   = 1'b0;
    execute_stall  = 1'b0;
    execute_bubble = 1'b0;
    flush          = 1'b0;
    accept         = 1'b0;

    if (i_memory_busy) begin
      // Whole front end freezes behind the bus. A redirect seen in RUN is
      // parked so it can be flushed once memory frees up; an ongoing flush
      // keeps killing fetch/decode but its countdown pauses.
      fetch_stall   = 1'b1;
      decode_stall  = 1'b1;
      execute_stall = 1'b1;
      if (state_q == FLUSH) begin
        flush = 1'b1;
      end else if (state_q == RUN && i_redirect) begin
        state_d = PENDING;
      end
    end else if (state_q == PENDING ||
                 (i_redirect && (state_q == RUN || state_q == FLUSH))) begin
      accept         = 1'b1;
      flush          = 1'b1;
      execute_bubble = 1'b1;
      if (state_q == FLUSH && i_execute_busy) begin
        fetch_stall  = 1'b1;
        decode_stall = 1'b1;
      end
      if (MULTI) begin
        state_d = FLUSH;
        fc_d    = FC_LOAD;
      end else begin
        state_d = RUN;
        fc_d    = 3'd0;
      end
    end else if (state_q == FLUSH) begin
      flush          = 1'b1;
      execute_bubble = 1'b1;
      fetch_stall    = i_execute_busy;
      decode_stall   = i_execute_busy;
      fc_d           = fc_q - 3'd1;
      if (fc_q == 3'd1) begin
        state_d = RUN;
      end
    end else if (i_execute_busy) begin
      // Execute holds its own register while the multi-cycle op runs.
      fetch_stall  = 1'b1;
      decode_stall = 1'b1;
    end else if (luh) begin
      fetch_stall    = 1'b1;
      decode_stall   = 1'b1;
      execute_bubble = 1'b1;
    end
  end

  assign stall_cnt_d = stall_cnt_q + 32'(decode_stall);
  assign flush_cnt_d = flush_cnt_q + 32'(accept);

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_q     <= RUN;
      fc_q        <= 3'd0;
      stall_cnt_q <= 32'd0;
      flush_cnt_q <= 32'd0;
    end else begin
      state_q     <= state_d;
      fc_q        <= fc_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  // Reset forces every output low even before the first clock edge.
  assign o_fetch_stall    = !i_reset && fetch_stall;
  assign o_decode_stall   = !i_reset && decode_stall;
  assign o_execute_stall  = !i_reset && execute_stall;
  assign o_execute_bubble = !i_reset && execute_bubble;
  assign o_flush          = !i_reset && flush;
  assign o_stall_cycles   = i_reset ? 32'd0 : stall_cnt_q;
  assign o_flush_events   = i_reset ? 32'd0 : flush_cnt_q;

endmodule

// File: tb/tb_cpu_pipeline_control.sv
module tb_cpu_pipeline_control;

  logic       clk;
  logic       rst;
  logic       dv, ev, el, eb, mb, redir;
  logic [1:0] have;
  logic [4:0] rs1, rs2, rd;

  // Three instances share stimulus: FLUSH_CYCLES = 1, 2, 3 (index k -> k+1).
  logic        fs [3];
  logic        ds [3];
  logic        es [3];
  logic        bub[3];
  logic        fl [3];
  logic [31:0] sc [3];
  logic [31:0] fe [3];

  int n_chk  = 0;
  int n_fail = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  cpu_pipeline_control #(.FLUSH_CYCLES(1)) u_fc1 (
    .i_clock(clk), .i_reset(rst), .i_decode_valid(dv), .i_decode_have_rs(have),
    .i_decode_rs1(rs1), .i_decode_rs2(rs2), .i_execute_valid(ev),
    .i_execute_load(el), .i_execute_rd(rd), .i_execute_busy(eb),
    .i_memory_busy(mb), .i_redirect(redir), .o_fetch_stall(fs[0]),
    .o_decode_stall(ds[0]), .o_execute_stall(es[0]), .o_execute_bubble(bub[0]),
    .o_flush(fl[0]), .o_stall_cycles(sc[0]), .o_flush_events(fe[0]));

  cpu_pipeline_control #(.FLUSH_CYCLES(2)) u_fc2 (
    .i_clock(clk), .i_reset(rst), .i_decode_valid(dv), .i_decode_have_rs(have),
    .i_decode_rs1(rs1), .i_decode_rs2(rs2), .i_execute_valid(ev),
    .i_execute_load(el), .i_execute_rd(rd), .i_execute_busy(eb),
    .i_memory_busy(mb), .i_redirect(redir), .o_fetch_stall(fs[1]),
    .o_decode_stall(ds[1]), .o_execute_stall(es[1]), .o_execute_bubble(bub[1]),
    .o_flush(fl[1]), .o_stall_cycles(sc[1]), .o_flush_events(fe[1]));

  cpu_pipeline_control #(.FLUSH_CYCLES(3)) u_fc3 (
    .i_clock(clk), .i_reset(rst), .i_decode_valid(dv), .i_decode_have_rs(have),
    .i_decode_rs1(rs1), .i_decode_rs2(rs2), .i_execute_valid(ev),
    .i_execute_load(el), .i_execute_rd(rd), .i_execute_busy(eb),
    .i_memory_busy(mb), .i_redirect(redir), .o_fetch_stall(fs[2]),
    .o_decode_stall(ds[2]), .o_execute_stall(es[2]), .o_execute_bubble(bub[2]),
    .o_flush(fl[2]), .o_stall_cycles(sc[2]), .o_flush_events(fe[2]));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural reference model ----------------
  // rem  : flush cycles still owed after this one
  // pend : a redirect is parked behind memory-busy
  int          rem [3];
  bit          pend[3];
  int unsigned m_sc[3];
  int unsigned m_fe[3];

  initial begin
    for (int k = 0; k < 3; k++) begin
      rem[k] = 0; pend[k] = 0; m_sc[k] = 0; m_fe[k] = 0;
    end
  end

  always @(negedge clk) begin
    bit luh;
    bit xfs, xds, xes, xbub, xfl, inflush;
    luh = dv && ev && el && (rd != 5'd0) &&
          ((have[0] && rs1 == rd) || (have[1] && rs2 == rd));
    for (int k = 0; k < 3; k++) begin
      xfs = 0; xds = 0; xes = 0; xbub = 0; xfl = 0;
      if (rst) begin
        chk($sformatf("rst_sc[%0d]", k), sc[k], 32'd0);
        chk($sformatf("rst_fe[%0d]", k), fe[k], 32'd0);
        rem[k] = 0; pend[k] = 0; m_sc[k] = 0; m_fe[k] = 0;
      end else begin
        chk($sformatf("stall_cycles[%0d]", k), sc[k], m_sc[k]);
        chk($sformatf("flush_events[%0d]", k), fe[k], m_fe[k]);
        inflush = (rem[k] > 0);
        if (mb) begin
          xfs = 1; xds = 1; xes = 1;
          xfl = inflush;
          if (redir && !inflush) pend[k] = 1;
        end else if (pend[k] || redir) begin
          xfl = 1; xbub = 1;
          if (inflush && eb) begin xfs = 1; xds = 1; end
          m_fe[k]++;
          rem[k]  = k;          // FLUSH_CYCLES - 1
          pend[k] = 0;
        end else if (inflush) begin
          xfl = 1; xbub = 1;
          xfs = eb; xds = eb;
          rem[k]--;
        end else if (eb) begin
          xfs = 1; xds = 1;
        end else if (luh) begin
          xfs = 1; xds = 1; xbub = 1;
        end
        if (xds) m_sc[k]++;
      end
      chk($sformatf("fetch_stall[%0d]", k),    32'(fs[k]),  32'(xfs));
      chk($sformatf("decode_stall[%0d]", k),   32'(ds[k]),  32'(xds));
      chk($sformatf("execute_stall[%0d]", k),  32'(es[k]),  32'(xes));
      chk($sformatf("execute_bubble[%0d]", k), 32'(bub[k]), 32'(xbub));
      chk($sformatf("flush[%0d]", k),          32'(fl[k]),  32'(xfl));
    end
  end

  // ---------------- stimulus ----------------
  task automatic idle();
    dv = 0; ev = 0; el = 0; eb = 0; mb = 0; redir = 0;
    have = 2'b00; rs1 = 5'd0; rs2 = 5'd0; rd = 5'd0;
  endtask

  task automatic nxt();
    @(posedge clk); #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic do_rst();
    idle(); rst = 1; nxt(); rst = 0;
  endtask

  initial begin
    idle(); rst = 1;
    smp();
    chk("reset_flush", 32'(fl[1]), 32'd0);
    chk("reset_fstall", 32'(fs[1]), 32'd0);
    nxt(); rst = 0;

    // Load-use on rs2 = x5
    dv = 1; ev = 1; el = 1; rd = 5'd5; have = 2'b10; rs1 = 5'd3; rs2 = 5'd5;
    smp();
    chk("lu_fstall", 32'(fs[1]), 32'd1);
    chk("lu_dstall", 32'(ds[1]), 32'd1);
    chk("lu_bubble", 32'(bub[1]), 32'd1);
    chk("lu_estall", 32'(es[1]), 32'd0);
    nxt(); ev = 0;
    smp();
    chk("lu_clear", 32'(ds[1]), 32'd0);
    chk("lu_count", sc[1], 32'd1);
    nxt();

    // x0 destination and unread operand never stall
    idle(); dv = 1; ev = 1; el = 1; rd = 5'd0; rs1 = 5'd0; have = 2'b01;
    smp(); chk("x0_nostall", 32'(ds[1]), 32'd0);
    nxt(); rd = 5'd7; rs1 = 5'd7; have = 2'b00;
    smp(); chk("unread_nostall", 32'(ds[1]), 32'd0);
    nxt();

    // Redirect pulse: FLUSH_CYCLES=2 flushes T,T+1; FLUSH_CYCLES=1 only T
    do_rst();
    redir = 1;
    smp(); chk("rd_T_fc2", 32'(fl[1]), 32'd1); chk("rd_T_fc1", 32'(fl[0]), 32'd1);
    nxt(); redir = 0;
    smp(); chk("rd_T1_fc2", 32'(fl[1]), 32'd1); chk("rd_T1_fc1", 32'(fl[0]), 32'd0);
    nxt();
    smp(); chk("rd_T2_fc2", 32'(fl[1]), 32'd0); chk("rd_events_fc2", fe[1], 32'd1);
    chk("rd_events_fc1", fe[0], 32'd1);
    nxt();

    // Redirect under memory busy for 3 cycles
    do_rst();
    redir = 1; mb = 1;
    for (int i = 0; i < 3; i++) begin
      smp();
      chk("mb_estall", 32'(es[1]), 32'd1);
      chk("mb_dstall", 32'(ds[1]), 32'd1);
      chk("mb_noflush", 32'(fl[1]), 32'd0);
      nxt(); redir = 0;
    end
    mb = 0;
    smp(); chk("mb_flush_c4", 32'(fl[1]), 32'd1);
    nxt();
    smp(); chk("mb_flush_c5", 32'(fl[1]), 32'd1); chk("mb_events", fe[1], 32'd1);
    nxt();
    smp(); chk("mb_flush_end", 32'(fl[1]), 32'd0);
    nxt();

    // Back-to-back redirects, FLUSH_CYCLES=3
    do_rst();
    redir = 1;
    smp(); chk("bb_c1", 32'(fl[2]), 32'd1);
    nxt();
    smp(); chk("bb_c2", 32'(fl[2]), 32'd1);
    nxt(); redir = 0;
    smp(); chk("bb_c3", 32'(fl[2]), 32'd1);
    nxt();
    smp(); chk("bb_c4", 32'(fl[2]), 32'd1);
    nxt();
    smp(); chk("bb_c5", 32'(fl[2]), 32'd0); chk("bb_events", fe[2], 32'd2);
    nxt();

    // Execute busy for 5 cycles
    do_rst();
    eb = 1;
    for (int i = 0; i < 5; i++) begin
      smp();
      chk("eb_fstall", 32'(fs[1]), 32'd1);
      chk("eb_estall", 32'(es[1]), 32'd0);
      nxt();
    end
    eb = 0;
    smp(); chk("eb_count", sc[1], 32'd5);
    nxt();

    // Reset on cycle 3 of a FLUSH (FLUSH_CYCLES=3)
    redir = 1;
    smp(); nxt(); redir = 0;
    smp(); nxt();
    rst = 1;
    smp(); chk("rstf_during", 32'(fl[2]), 32'd0);
    nxt(); rst = 0;
    smp();
    chk("rstf_flush", 32'(fl[2]), 32'd0);
    chk("rstf_events", fe[2], 32'd0);
    chk("rstf_stalls", sc[1], 32'd0);
    nxt();

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      rst   = ($urandom_range(0, 199) == 0);
      dv    = 1'($urandom);
      ev    = 1'($urandom);
      el    = 1'($urandom);
      have  = 2'($urandom);
      rs1   = 5'($urandom_range(0, 3));
      rs2   = 5'($urandom_range(0, 3));
      rd    = 5'($urandom_range(0, 3));
      eb    = ($urandom_range(0, 3) == 0);
      mb    = ($urandom_range(0, 4) == 0);
      redir = ($urandom_range(0, 6) == 0);
      nxt();
    end
    idle(); rst = 0;
    smp();
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
